// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_adder_ctrl.
// Optional out_ovf is present only when ADD_SEQ_OVF_EN is defined.
interface nibble_serial_adder_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             busy;
`ifdef ADD_SEQ_OVF_EN
   logic             out_ovf;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, busy, out_ovf
   );
   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, busy, out_ovf
   );
`else
   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, busy
   );
   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, busy
   );
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one 4-bit carry-lookahead slice, one nibble per cycle.
// Define ADD_SEQ_OVF_EN to add the signed-overflow output out_ovf.
module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   nibble_serial_adder_ctrl_if.slave   io
);
   localparam int NIB   = WIDTH / 4;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic [IDX_W-1:0]   r_idx;
   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_busy;
   logic               w_last;
   logic [3:0]         w_a_nib;
   logic [3:0]         w_b_nib;
   logic [3:0]         w_p;
   logic [3:0]         w_g;
   logic [4:0]         w_c;
   logic [3:0]         w_slice_sum;

   assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
   assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];
   assign w_last  = (r_idx == IDX_W'(NIB - 1));

   // Carry-lookahead slice: every carry is a flat function of p, g and the incoming carry.
   assign w_p    = w_a_nib ^ w_b_nib;
   assign w_g    = w_a_nib & w_b_nib;
   assign w_c[0] = r_carry;
   assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   assign w_slice_sum = w_p ^ w_c[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      w_busy       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (io.in_valid) w_state_next = S_RUN;
         end
         S_RUN: begin
            w_busy = 1'b1;
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            w_busy      = 1'b1;
            w_out_valid = 1'b1;
            if (io.out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io.in_valid) begin
                  r_a     <= io.in_a;
                  r_b     <= io.in_b;
                  r_carry <= io.in_cin;
                  r_idx   <= '0;
               end
            end
            S_RUN: begin
               r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
               r_carry                    <= w_c[4];
               r_idx                      <= r_idx + 1'b1;
               if (w_last) r_cout <= w_c[4];
            end
            default: ;
         endcase
      end
   end

`ifdef ADD_SEQ_OVF_EN
   logic r_ovf;

   // The top nibble is being written on the DONE transition, so its MSB comes from the slice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_RUN && w_last) begin
         r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_slice_sum[3] != r_a[WIDTH-1]);
      end
   end

   assign io.out_ovf = r_ovf;
`endif

   assign io.in_ready  = w_in_ready;
   assign io.out_valid = w_out_valid;
   assign io.busy      = w_busy;
   assign io.out_sum   = r_sum;
   assign io.out_cout  = r_cout;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with a result scoreboard.
// Define ADD_SEQ_OVF_EN to also check out_ovf.
module tb_nibble_serial_adder_ctrl;
   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   exp_t sb_q[$];

   nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

   nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total_cnt++;
      assert (obs === expv) pass_cnt++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands for one cycle in IDLE and queue the reference result.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
      logic [WIDTH:0] full;
      exp_t e;
      full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      e.sum  = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
      sb_q.push_back(e);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_valid = 1'b1;
      check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("busy_after_accept", 32'(bus.busy), 32'd1);
      $display("accept a=0x%04h b=0x%04h cin=%0d", a, b, cin);
   endtask

   // elapsed: cycles already consumed since the accepting edge; hold: cycles to stall out_ready.
   task automatic collect(input int elapsed, input int hold);
      int   cyc;
      exp_t e;
      logic [WIDTH-1:0] first_sum;
      cyc = elapsed;
      while (bus.out_valid !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      check("latency", 32'(cyc), 32'(NIB));
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      check("out_sum", 32'(bus.out_sum), 32'(e.sum));
      check("out_cout", 32'(bus.out_cout), 32'(e.cout));
`ifdef ADD_SEQ_OVF_EN
      check("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
`endif
      $display("result sum=0x%04h cout=%0d exp_sum=0x%04h exp_cout=%0d", bus.out_sum, bus.out_cout, e.sum, e.cout);
      first_sum = bus.out_sum;
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_sum", 32'(bus.out_sum), 32'(first_sum));
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("valid_drop", 32'(bus.out_valid), 32'd0);
      check("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      #12;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_sum", 32'(bus.out_sum), 32'd0);
      check("rst_out_cout", 32'(bus.out_cout), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      tick();

      // out_ready held high throughout, including while idle.
      bus.out_ready = 1'b1;
      tick();
      check("idle_out_ready_no_effect", 32'(bus.out_valid), 32'd0);
      send(16'h0FFF, 16'h0001, 1'b0);
      bus.out_ready = 1'b1;
      collect(0, 0);

      send(16'hFFFF, 16'h0000, 1'b1);
      collect(0, 0);

      send(16'h1234, 16'h4321, 1'b0);
      collect(0, 5);

      // Operand request during RUN must be ignored; latched operands must not change.
      send(16'hAAAA, 16'h5555, 1'b0);
      bus.in_a     = 16'h0001;
      bus.in_b     = 16'h0001;
      bus.in_valid = 1'b1;
      check("in_ready_in_run", 32'(bus.in_ready), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      collect(1, 0);
      send(16'h0100, 16'h0200, 1'b1);
      collect(0, 0);

      // Reset during the second RUN cycle discards the operation.
      send(16'h1111, 16'h2222, 1'b0);
      void'(sb_q.pop_back());
      tick();
      rst_n = 1'b0;
      #1;
      check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrun_rst_out_sum", 32'(bus.out_sum), 32'd0);
      check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrun_rst_busy", 32'(bus.busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("after_rst_no_result", 32'(bus.out_valid), 32'd0);
      send(16'h0002, 16'h0003, 1'b0);
      collect(0, 0);

      for (int i = 0; i < 4; i++) begin
         send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         collect(0, i);
      end

`ifdef ADD_SEQ_OVF_EN
      send(16'h7FFF, 16'h0001, 1'b0);
      collect(0, 0);
      send(16'h8000, 16'h8000, 1'b0);
      collect(0, 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
